// File: rtl/audio_capture_fsm.sv
// ---------------------------------------------------------------------------
// audio_capture_fsm
//
// Purpose:
//   Record-side sequencer. On every sampling pulse it pops one left-channel
//   sample from the audio codec ADC FIFO and packs two consecutive samples
//   into one 32-bit word. Each finished word is written to the next
//   sequential message-RAM address. Capture stops in DONE after the last
//   RAM word has been written.
//
// Parameters:
//   ADDR_W         RAM word-address width (capture covers 0 .. 2^ADDR_W-1)
//
// Ports:
//   CLK50MHZ       in   system clock, the only clock
//   reset          in   synchronous, active-high
//   CLK_sampling   in   one-cycle pulse per sample period (already
//                       synchronised and edge-detected)
//   start          in   level, 1 = capture enabled, 0 = abort to idle
//   pause          in   level, 1 = ignore sampling pulses, hold position
//   read_ready     in   codec ADC FIFO holds a sample
//   readdata_left  in   24-bit left sample, valid while read_ready = 1
//   read           out  one-cycle pop strobe to the codec
//   ram_wren       out  one-cycle RAM write enable
//   ram_wraddress  out  RAM word address
//   ram_data       out  packed word, first sample [15:0], second [31:16]
//   sample_out     out  most recently captured sample (for HEX display)
//   overrun_count  out  dropped sampling pulses, saturating at 255
//   busy           out  1 in every state except IDLE and DONE
//   done           out  1 while in DONE
//
// Every output comes straight from a flop. Each flop <sig>_q is loaded
// from <sig>_d, which is computed in the single always_comb block below.
// ---------------------------------------------------------------------------
module audio_capture_fsm #(
  parameter int ADDR_W = 15
) (
  input  logic              CLK50MHZ,
  input  logic              reset,
  input  logic              CLK_sampling,
  input  logic              start,
  input  logic              pause,
  input  logic              read_ready,
  input  logic [23:0]       readdata_left,
  output logic              read,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [31:0]       ram_data,
  output logic [15:0]       sample_out,
  output logic [7:0]        overrun_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_WAIT_READY,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                half_q, half_d;
  logic [15:0]         low_q, low_d;
  logic                read_q, read_d;
  logic                wren_q, wren_d;
  logic [31:0]         data_q, data_d;
  logic [15:0]         sample_q, sample_d;
  logic [7:0]          overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [15:0]         sample_w;
  logic                late_pulse;

  // The codec delivers 24-bit samples. Only the top 16 bits are stored.
  // The low byte is dropped on purpose. It is folded into an "unused"
  // signal so that the discard is visible in the code.
  logic                unused_sample_bits;
  assign unused_sample_bits = ^readdata_left[7:0];
  assign sample_w           = readdata_left[23:8];

  // A sampling pulse is "late" when the FSM is still busy with the
  // previous sample. Such a pulse is dropped and counted, never queued.
  // Pulses seen in WAIT_EDGE, IDLE or DONE are not overruns.
  assign late_pulse = CLK_sampling &&
                      ((state_q == S_WAIT_READY) ||
                       (state_q == S_READ)       ||
                       (state_q == S_WRITE));

  // Next-state and next-output logic.
  // The strobes, busy and done are derived from the *next* state. This
  // keeps them aligned with the state register while staying registered.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    half_d    = half_q;
    low_d     = low_q;
    data_d    = data_q;
    sample_d  = sample_q;
    overrun_d = overrun_q;

    if (late_pulse && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        half_d = 1'b0;
        if (start) begin
          state_d   = S_WAIT_EDGE;
          overrun_d = 8'd0;
        end
      end

      // Paused pulses are ignored completely. Position and half are kept,
      // so capture resumes exactly where it stopped.
      S_WAIT_EDGE: begin
        if (!start) begin
          state_d = S_IDLE;
          addr_d  = '0;
          half_d  = 1'b0;
        end else if (CLK_sampling && !pause) begin
          state_d = S_WAIT_READY;
        end
      end

      // Aborting here discards any half-packed word. No pop is issued.
      S_WAIT_READY: begin
        if (!start) begin
          state_d = S_IDLE;
          addr_d  = '0;
          half_d  = 1'b0;
        end else if (read_ready) begin
          state_d = S_READ;
        end
      end

      // The pop strobe is high during this cycle. The codec still presents
      // the popped sample on readdata_left, so it is captured at the end of
      // the cycle.
      S_READ: begin
        sample_d = sample_w;
        if (!half_q) begin
          low_d   = sample_w;
          half_d  = 1'b1;
          state_d = S_WAIT_EDGE;
        end else begin
          data_d  = {sample_w, low_q};
          half_d  = 1'b0;
          state_d = S_WRITE;
        end
      end

      // The address advances only after the write cycle. This keeps
      // ram_wraddress equal to the written address while ram_wren is high.
      S_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_WAIT_EDGE;
        end
      end

      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
          addr_d  = '0;
          half_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        half_d  = 1'b0;
      end
    endcase

    read_d = (state_d == S_READ);
    wren_d = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers, with a synchronous reset to IDLE.
  // Reset clears every output, from any state.
  always_ff @(posedge CLK50MHZ) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      half_q    <= 1'b0;
      low_q     <= 16'd0;
      read_q    <= 1'b0;
      wren_q    <= 1'b0;
      data_q    <= 32'd0;
      sample_q  <= 16'd0;
      overrun_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      half_q    <= half_d;
      low_q     <= low_d;
      read_q    <= read_d;
      wren_q    <= wren_d;
      data_q    <= data_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign read          = read_q;
  assign ram_wren      = wren_q;
  assign ram_wraddress = addr_q;
  assign ram_data      = data_q;
  assign sample_out    = sample_q;
  assign overrun_count = overrun_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_audio_capture_fsm.sv
// ---------------------------------------------------------------------------
// tb_audio_capture_fsm
//
// Directed bench for audio_capture_fsm. It uses two instances that share
// every input:
//   - dut   uses the default ADDR_W = 15. It is used for most checks.
//   - dut_s uses ADDR_W = 2. It is used to reach DONE in a few writes.
//
// A negedge monitor keeps a log of every pop and every RAM write. The
// directed sequence then checks that log against hand-computed values.
// ---------------------------------------------------------------------------
module tb_audio_capture_fsm;

  logic        CLK50MHZ = 1'b0;
  logic        reset;
  logic        CLK_sampling;
  logic        start;
  logic        pause;
  logic        read_ready;
  logic [23:0] readdata_left;

  logic        read, ram_wren, busy, done;
  logic [14:0] ram_wraddress;
  logic [31:0] ram_data;
  logic [15:0] sample_out;
  logic [7:0]  overrun_count;

  logic        read_s, ram_wren_s, busy_s, done_s;
  logic [1:0]  ram_wraddress_s;
  logic [31:0] ram_data_s;
  logic [15:0] sample_out_s;
  logic [7:0]  overrun_count_s;

  int tests    = 0;
  int failures = 0;

  int          read_cnt   = 0;
  int          read_cnt_s = 0;
  logic [14:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [1:0]  wr_addr_s[$];
  logic [31:0] wr_data_s[$];
  logic        prev_read = 1'b0;
  logic        prev_wren = 1'b0;

  always #5 CLK50MHZ = ~CLK50MHZ;

  audio_capture_fsm #(.ADDR_W(15)) dut (
    .CLK50MHZ      (CLK50MHZ),
    .reset         (reset),
    .CLK_sampling  (CLK_sampling),
    .start         (start),
    .pause         (pause),
    .read_ready    (read_ready),
    .readdata_left (readdata_left),
    .read          (read),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .sample_out    (sample_out),
    .overrun_count (overrun_count),
    .busy          (busy),
    .done          (done)
  );

  audio_capture_fsm #(.ADDR_W(2)) dut_s (
    .CLK50MHZ      (CLK50MHZ),
    .reset         (reset),
    .CLK_sampling  (CLK_sampling),
    .start         (start),
    .pause         (pause),
    .read_ready    (read_ready),
    .readdata_left (readdata_left),
    .read          (read_s),
    .ram_wren      (ram_wren_s),
    .ram_wraddress (ram_wraddress_s),
    .ram_data      (ram_data_s),
    .sample_out    (sample_out_s),
    .overrun_count (overrun_count_s),
    .busy          (busy_s),
    .done          (done_s)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK50MHZ);
    #1;
  endtask

  // Present one sampling pulse together with the codec FIFO state, then
  // let the clock run for `cycles` edges in total.
  task automatic applyStimulus(input logic [23:0] data, input logic ready,
                               input int cycles);
    readdata_left = data;
    read_ready    = ready;
    CLK_sampling  = 1'b1;
    tick();
    CLK_sampling  = 1'b0;
    repeat (cycles - 1) tick();
  endtask

  // Log pops and writes on the falling edge, away from the DUT update.
  // The monitor also checks that the strobes never collide and never
  // repeat on back-to-back cycles.
  always @(negedge CLK50MHZ) begin
    if (read) read_cnt++;
    if (ram_wren) begin
      wr_addr.push_back(ram_wraddress);
      wr_data.push_back(ram_data);
    end
    if (read || ram_wren)
      checkOutput("strobe_excl",
                  {29'd0, read && ram_wren, read && prev_read, ram_wren && prev_wren},
                  32'd0);
    prev_read = read;
    prev_wren = ram_wren;
    if (read_s) read_cnt_s++;
    if (ram_wren_s) begin
      wr_addr_s.push_back(ram_wraddress_s);
      wr_data_s.push_back(ram_data_s);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int rc;

    reset = 1'b1; start = 1'b0; pause = 1'b0; CLK_sampling = 1'b0;
    read_ready = 1'b0; readdata_left = 24'd0;
    tick(); tick();

    // Reset state
    checkOutput("rst_read",    {31'd0, read}, 32'd0);
    checkOutput("rst_wren",    {31'd0, ram_wren}, 32'd0);
    checkOutput("rst_addr",    {17'd0, ram_wraddress}, 32'd0);
    checkOutput("rst_data",    ram_data, 32'd0);
    checkOutput("rst_sample",  {16'd0, sample_out}, 32'd0);
    checkOutput("rst_overrun", {24'd0, overrun_count}, 32'd0);
    checkOutput("rst_busy",    {31'd0, busy}, 32'd0);
    checkOutput("rst_done",    {31'd0, done}, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    tick();
    checkOutput("start_busy", {31'd0, busy}, 32'd1);

    // Pairing of two samples into one word at address 0
    read_cnt = 0;
    applyStimulus(24'h123456, 1'b1, 2);
    checkOutput("pair_read1", {31'd0, read}, 32'd1);
    tick(); tick();
    checkOutput("pair_read1_off", {31'd0, read}, 32'd0);
    checkOutput("pair_sample1", {16'd0, sample_out}, 32'h1234);
    applyStimulus(24'hABCDEF, 1'b1, 3);
    checkOutput("pair_wren", {31'd0, ram_wren}, 32'd1);
    checkOutput("pair_waddr", {17'd0, ram_wraddress}, 32'd0);
    checkOutput("pair_wdata", ram_data, 32'hABCD1234);
    checkOutput("pair_sample2", {16'd0, sample_out}, 32'hABCD);
    tick();
    checkOutput("pair_wren_off", {31'd0, ram_wren}, 32'd0);
    checkOutput("pair_addr_next", {17'd0, ram_wraddress}, 32'd1);
    checkOutput("pair_reads", 32'(read_cnt), 32'd2);
    checkOutput("pair_writes", 32'(wr_addr.size()), 32'd1);

    // Reset in the middle of WAIT_READY with address 5
    for (int i = 0; i < 8; i++) applyStimulus(24'h010100 * 24'(i + 1), 1'b1, 4);
    applyStimulus(24'h0, 1'b0, 2);
    checkOutput("mid_addr5", {17'd0, ram_wraddress}, 32'd5);
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("mrst_addr",   {17'd0, ram_wraddress}, 32'd0);
    checkOutput("mrst_data",   ram_data, 32'd0);
    checkOutput("mrst_sample", {16'd0, sample_out}, 32'd0);
    checkOutput("mrst_busy",   {31'd0, busy}, 32'd0);
    checkOutput("mrst_read",   {31'd0, read}, 32'd0);
    reset = 1'b0;
    tick();
    n = wr_addr.size();
    applyStimulus(24'h111100, 1'b1, 4);
    applyStimulus(24'h222200, 1'b1, 4);
    checkOutput("rstart_count", 32'(wr_addr.size()), 32'(n + 1));
    checkOutput("rstart_addr", {17'd0, wr_addr[n]}, 32'd0);
    checkOutput("rstart_data", wr_data[n], 32'h22221111);

    // Abort with half a word pending
    applyStimulus(24'h999900, 1'b1, 4);
    applyStimulus(24'h0, 1'b0, 2);
    rc = read_cnt;
    n  = wr_addr.size();
    start = 1'b0;
    tick();
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("abort_reads", 32'(read_cnt), 32'(rc));
    checkOutput("abort_writes", 32'(wr_addr.size()), 32'(n));
    start = 1'b1;
    tick();
    applyStimulus(24'h333300, 1'b1, 4);
    applyStimulus(24'h444400, 1'b1, 4);
    checkOutput("abort_count", 32'(wr_addr.size()), 32'(n + 1));
    checkOutput("abort_addr", {17'd0, wr_addr[n]}, 32'd0);
    checkOutput("abort_data", wr_data[n], 32'h44443333);
    checkOutput("abort_reads2", 32'(read_cnt), 32'(rc + 2));

    // Pause holds position, does not pop and does not count overruns
    start = 1'b0; tick(); start = 1'b1; tick();
    applyStimulus(24'h555500, 1'b1, 4);
    rc = read_cnt;
    pause = 1'b1;
    repeat (5) applyStimulus(24'h777700, 1'b1, 4);
    checkOutput("pause_reads", 32'(read_cnt), 32'(rc));
    checkOutput("pause_overrun", {24'd0, overrun_count}, 32'd0);
    pause = 1'b0;
    n = wr_addr.size();
    applyStimulus(24'h666600, 1'b1, 4);
    checkOutput("pause_count", 32'(wr_addr.size()), 32'(n + 1));
    checkOutput("pause_addr", {17'd0, wr_addr[n]}, 32'd0);
    checkOutput("pause_data", wr_data[n], 32'h66665555);

    // Overrun counting and saturation
    start = 1'b0; tick(); start = 1'b1; tick();
    rc = read_cnt;
    repeat (4) applyStimulus(24'h0, 1'b0, 4);
    checkOutput("ovr_3", {24'd0, overrun_count}, 32'd3);
    checkOutput("ovr_reads", 32'(read_cnt), 32'(rc));
    repeat (300) applyStimulus(24'h0, 1'b0, 4);
    checkOutput("ovr_sat", {24'd0, overrun_count}, 32'd255);
    start = 1'b0; tick(); start = 1'b1; tick();
    checkOutput("ovr_clear", {24'd0, overrun_count}, 32'd0);

    // Fill the small (ADDR_W = 2) instance up to DONE
    reset = 1'b1; tick(); reset = 1'b0; tick();
    wr_addr_s.delete();
    wr_data_s.delete();
    read_cnt_s = 0;
    for (int i = 0; i < 8; i++) applyStimulus(24'h010000 * 24'(i + 1), 1'b1, 4);
    checkOutput("full_writes", 32'(wr_addr_s.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("full_addr", {30'd0, wr_addr_s[i]}, 32'(i));
    checkOutput("full_last_data", wr_data_s[3], 32'h08000700);
    checkOutput("full_done", {31'd0, done_s}, 32'd1);
    checkOutput("full_busy", {31'd0, busy_s}, 32'd0);
    rc = read_cnt_s;
    repeat (3) applyStimulus(24'hFFFF00, 1'b1, 4);
    checkOutput("done_reads", 32'(read_cnt_s), 32'(rc));
    checkOutput("done_overrun", {24'd0, overrun_count_s}, 32'd0);
    checkOutput("done_writes", 32'(wr_addr_s.size()), 32'd4);
    start = 1'b0;
    tick();
    checkOutput("done_exit", {31'd0, done_s}, 32'd0);
    checkOutput("done_exit_busy", {31'd0, busy_s}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
